// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS subset: opcodes, funct codes,
// ALU control codes and the controller state encoding.
package mips_pkg;

  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [2:0] {
    AluAnd  = 3'b000,
    AluOr   = 3'b001,
    AluAdd  = 3'b010,
    AluZero = 3'b011,
    AluSub  = 3'b110,
    AluSlt  = 3'b111
  } alu_ctl_e;

  // StMemAdr is the A+imm step shared by lb, sb and addi (it is addi's execute step).
  typedef enum logic [3:0] {
    StFetch1  = 4'd0,
    StFetch2  = 4'd1,
    StFetch3  = 4'd2,
    StFetch4  = 4'd3,
    StDecode  = 4'd4,
    StMemAdr  = 4'd5,
    StLbRd    = 4'd6,
    StLbWr    = 4'd7,
    StSbWr    = 4'd8,
    StRtypeEx = 4'd9,
    StRtypeWr = 4'd10,
    StBeqEx   = 4'd11,
    StJEx     = 4'd12,
    StAddiWr  = 4'd13
  } state_e;

endpackage

// File: rtl/mips_ctrl.sv
// Controller: instruction-sequencing FSM with registered store strobe,
// plus the ALU operation decode.
module mips_ctrl
  import mips_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output state_e   state,
  output logic     memwrite,
  output alu_ctl_e alucontrol
);

  // State sequencing; memwrite is registered so it is high only while in StSbWr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StFetch1;
      memwrite <= 1'b0;
    end else begin
      memwrite <= (state == StMemAdr) && (op == OpSb);
      unique case (state)
        StFetch1: state <= StFetch2;
        StFetch2: state <= StFetch3;
        StFetch3: state <= StFetch4;
        StFetch4: state <= StDecode;
        StDecode: begin
          case (op)
            OpLb, OpSb, OpAddi: state <= StMemAdr;
            OpRtype:            state <= StRtypeEx;
            OpBeq:              state <= StBeqEx;
            OpJ:                state <= StJEx;
            default:            state <= StFetch1;
          endcase
        end
        StMemAdr: begin
          case (op)
            OpLb:    state <= StLbRd;
            OpSb:    state <= StSbWr;
            default: state <= StAddiWr;
          endcase
        end
        StLbRd:    state <= StLbWr;
        StRtypeEx: state <= StRtypeWr;
        default:   state <= StFetch1;
      endcase
    end
  end

  // ALU operation: funct-driven for R-type, subtract for beq, add otherwise.
  always_comb begin
    alucontrol = AluAdd;
    if (state == StRtypeEx) begin
      case (funct)
        FnAdd:   alucontrol = AluAdd;
        FnSub:   alucontrol = AluSub;
        FnAnd:   alucontrol = AluAnd;
        FnOr:    alucontrol = AluOr;
        FnSlt:   alucontrol = AluSlt;
        default: alucontrol = AluZero;
      endcase
    end else if (state == StBeqEx) begin
      alucontrol = AluSub;
    end
  end

endmodule

// File: rtl/mips_datapath.sv
// Datapath: PC, instruction register, A/B/ALUOut/data registers, ALU and
// the 2-read/1-write register file. Actions are keyed off the controller state.
module mips_datapath
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  state_e           state,
  input  alu_ctl_e         alucontrol,
  input  logic [WIDTH-1:0] memdata,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] writedata
);

  localparam logic [WIDTH-1:0] PcOne = WIDTH'(1);

  logic [WIDTH-1:0] pc_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0]      ir_q;
  logic [WIDTH-1:0] rf [2**REGBITS];

  logic [REGBITS-1:0] rs, rt, rd;
  logic [WIDTH-1:0]   imm, br_off, rd1, rd2;
  logic [WIDTH-1:0]   alu_b, sum, diff, alu_y;
  logic               rf_we;
  logic [REGBITS-1:0] rf_wa;
  logic [WIDTH-1:0]   rf_wd;
  logic               unused_ir;

  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs     = ir_q[21 +: REGBITS];
  assign rt     = ir_q[16 +: REGBITS];
  assign rd     = ir_q[11 +: REGBITS];
  assign imm    = ir_q[WIDTH-1:0];
  // Word offset scaled to bytes; serves as branch offset and jump target.
  assign br_off = {ir_q[WIDTH-3:0], 2'b00};
  assign unused_ir = ^ir_q;

  assign rd1 = (rs == '0) ? '0 : rf[rs];
  assign rd2 = (rt == '0) ? '0 : rf[rt];

  assign addr      = (state == StLbRd || state == StSbWr) ? aluout_q : pc_q;
  assign writedata = b_q;

  // ALU: second operand is the immediate only in the address/addi step.
  assign alu_b = (state == StMemAdr) ? imm : b_q;
  assign sum   = a_q + alu_b;
  assign diff  = a_q - alu_b;

  // ALU result selection.
  always_comb begin
    alu_y = '0;
    case (alucontrol)
      AluAnd:  alu_y = a_q & alu_b;
      AluOr:   alu_y = a_q | alu_b;
      AluAdd:  alu_y = sum;
      AluSub:  alu_y = diff;
      AluSlt:  alu_y = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      default: alu_y = '0;
    endcase
  end

  // Architectural and staging register updates per controller state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      case (state)
        StFetch1: begin ir_q[7:0]   <= memdata[7:0]; pc_q <= pc_q + PcOne; end
        StFetch2: begin ir_q[15:8]  <= memdata[7:0]; pc_q <= pc_q + PcOne; end
        StFetch3: begin ir_q[23:16] <= memdata[7:0]; pc_q <= pc_q + PcOne; end
        StFetch4: begin ir_q[31:24] <= memdata[7:0]; pc_q <= pc_q + PcOne; end
        StDecode: begin
          a_q      <= rd1;
          b_q      <= rd2;
          aluout_q <= pc_q + br_off;
        end
        StMemAdr, StRtypeEx: aluout_q <= alu_y;
        StLbRd:              mdr_q    <= memdata;
        StBeqEx:             if (alu_y == '0) pc_q <= aluout_q;
        StJEx:               pc_q <= br_off;
        default: ;
      endcase
    end
  end

  // Register-file write port selection.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = aluout_q;
    case (state)
      StLbWr:    begin rf_we = 1'b1; rf_wa = rt; rf_wd = mdr_q; end
      StRtypeWr: begin rf_we = 1'b1; rf_wa = rd; end
      StAddiWr:  begin rf_we = 1'b1; rf_wa = rt; end
      default: ;
    endcase
  end

  // Register file write; register 0 is never written.
  always_ff @(posedge clk) begin
    if (rf_we && rf_wa != '0) rf[rf_wa] <= rf_wd;
  end

endmodule

// File: rtl/mips_cpu.sv
// Multicycle, non-pipelined MIPS subset with a byte-wide memory port.
module mips_cpu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  output logic             memwrite,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] writedata
);

  state_e     state;
  alu_ctl_e   alucontrol;
  logic [5:0] op, funct;

  mips_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .state      (state),
    .memwrite   (memwrite),
    .alucontrol (alucontrol)
  );

  mips_datapath #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .alucontrol (alucontrol),
    .memdata    (memdata),
    .op         (op),
    .funct      (funct),
    .addr       (addr),
    .writedata  (writedata)
  );

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: instruction-level reference model producing the expected
// per-cycle bus trace, directed programs with literal store expectations,
// and randomized programs.
module tb_mips_cpu;

  localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] memdata, addr, writedata;
  logic       memwrite;

  always #5 clk = ~clk;

  mips_cpu #(.WIDTH(8), .REGBITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .memdata   (memdata),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata)
  );

  // External byte memory
  logic [7:0] mem [256];
  assign memdata = mem[addr];
  always @(posedge clk) if (memwrite) mem[addr] <= writedata;

  // Reference model state
  typedef struct packed {
    logic [7:0] addr;
    logic       mw;
    logic [7:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] m_mem [256];
  logic [7:0] m_reg [8];
  logic [7:0] m_pc;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  checking = 1'b0;
  int  cyc;
  int  st_cyc[$];
  logic [7:0] st_addr[$];
  logic [7:0] st_data[$];
  logic [7:0] addr_log [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] a, input logic mw, input logic [7:0] wd);
    exp_t e;
    e.addr = a;
    e.mw   = mw;
    e.wd   = wd;
    return e;
  endfunction

  task automatic wreg(input logic [2:0] idx, input logic [7:0] v);
    if (idx != 3'd0) m_reg[idx] = v;
  endtask

  // Execute one instruction architecturally and queue its bus trace.
  task automatic model_step();
    logic [31:0] ins;
    logic [7:0]  pc4, a, b, imm, ea, diff, r, off;
    logic [2:0]  rs, rt, rd;
    for (int k = 0; k < 4; k++) begin
      ins[8*k +: 8] = m_mem[8'(m_pc + 8'(k))];
      exp_q.push_back(mk(8'(m_pc + 8'(k)), 1'b0, 8'h00));
    end
    pc4 = m_pc + 8'd4;
    exp_q.push_back(mk(pc4, 1'b0, 8'h00));
    rs = ins[23:21]; rt = ins[18:16]; rd = ins[13:11]; imm = ins[7:0];
    a = m_reg[rs]; b = m_reg[rt];
    off = {ins[5:0], 2'b00};
    m_pc = pc4;
    case (ins[31:26])
      OP_LB: begin
        ea = a + imm;
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        exp_q.push_back(mk(ea, 1'b0, 8'h00));
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        wreg(rt, m_mem[ea]);
      end
      OP_SB: begin
        ea = a + imm;
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        exp_q.push_back(mk(ea, 1'b1, b));
        m_mem[ea] = b;
      end
      OP_R: begin
        diff = a - b;
        case (ins[5:0])
          F_ADD:   r = a + b;
          F_SUB:   r = diff;
          F_AND:   r = a & b;
          F_OR:    r = a | b;
          F_SLT:   r = (diff >= 8'h80) ? 8'd1 : 8'd0;
          default: r = 8'd0;
        endcase
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        wreg(rd, r);
      end
      OP_ADDI: begin
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        wreg(rt, a + imm);
      end
      OP_BEQ: begin
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        if (a == b) m_pc = pc4 + off;
      end
      OP_J: begin
        exp_q.push_back(mk(pc4, 1'b0, 8'h00));
        m_pc = off;
      end
      default: ;
    endcase
  endtask

  // Per-cycle comparison against the model trace.
  always @(negedge clk) begin
    if (checking) begin
      if (exp_q.size() == 0) model_step();
      cur = exp_q.pop_front();
      chk($sformatf("addr@cyc%0d", cyc), 32'(addr), 32'(cur.addr));
      chk($sformatf("memwrite@cyc%0d", cyc), 32'(memwrite), 32'(cur.mw));
      if (cur.mw) chk($sformatf("writedata@cyc%0d", cyc), 32'(writedata), 32'(cur.wd));
      if (memwrite === 1'b1) begin
        st_cyc.push_back(cyc);
        st_addr.push_back(addr);
        st_data.push_back(writedata);
      end
      if (cyc < 8) addr_log[cyc] = addr;
      cyc++;
    end
  end

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [7:0] imm);
    return {op, 5'(rs), 5'(rt), 8'h00, imm};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {OP_J, 26'(target)};
  endfunction

  task automatic put(input int w, input logic [31:0] ins);
    for (int k = 0; k < 4; k++) begin
      mem[8'(4*w + k)]   <= ins[8*k +: 8];
      m_mem[8'(4*w + k)]  = ins[8*k +: 8];
    end
  endtask

  task automatic clear_mem(input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = rnd ? 8'($urandom) : 8'h00;
      mem[i]   <= v;
      m_mem[i]  = v;
    end
  endtask

  task automatic run_prog(input int ncyc);
    reset = 1'b0;
    exp_q.delete();
    st_cyc.delete();
    st_addr.delete();
    st_data.delete();
    cyc  = 0;
    m_pc = 8'h00;
    for (int r = 0; r < 8; r++) m_reg[r] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", 32'(addr), 32'h0);
    chk("reset_memwrite", 32'(memwrite), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1 checking = 1'b0;
  endtask

  task automatic chk_one_store(input string name, input logic [7:0] a, input logic [7:0] d);
    chk({name, "_nstores"}, 32'(st_addr.size()), 32'd1);
    if (st_addr.size() == 1) begin
      chk({name, "_addr"}, 32'(st_addr[0]), 32'(a));
      chk({name, "_data"}, 32'(st_data[0]), 32'(d));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int sel;

    // Program 1: addi r1,r0,5 ; sb r1,76(r0) ; spin
    clear_mem(1'b0);
    put(0, enc_i(OP_ADDI, 0, 1, 8'd5));
    put(1, enc_i(OP_SB, 0, 1, 8'd76));
    put(2, enc_j(2));
    run_prog(40);
    for (int i = 0; i < 4; i++) chk($sformatf("first_fetch_addr%0d", i), 32'(addr_log[i]), 32'(i));
    chk_one_store("p1", 8'd76, 8'd5);
    if (st_cyc.size() == 1) chk("p1_store_cycle", 32'(st_cyc[0]), 32'd13);

    // Program 2: taken beq skips one instruction, not-taken beq falls through
    clear_mem(1'b0);
    put(0, enc_i(OP_ADDI, 0, 2, 8'd1));
    put(1, enc_i(OP_BEQ, 0, 0, 8'd1));
    put(2, enc_i(OP_ADDI, 0, 2, 8'd9));
    put(3, enc_i(OP_BEQ, 2, 0, 8'd1));
    put(4, enc_i(OP_SB, 0, 2, 8'd80));
    put(5, enc_j(5));
    run_prog(50);
    chk_one_store("p2", 8'd80, 8'd1);

    // Program 3: full instruction mix ending in store of 7 to 76
    clear_mem(1'b0);
    put(0,  enc_i(OP_ADDI, 0, 2, 8'd5));
    put(1,  enc_i(OP_ADDI, 0, 3, 8'd12));
    put(2,  enc_r(3, 2, 4, F_SUB));
    put(3,  enc_r(3, 4, 5, F_AND));
    put(4,  enc_r(3, 2, 6, F_OR));
    put(5,  enc_r(3, 2, 1, F_SLT));
    put(6,  enc_r(5, 1, 5, F_ADD));
    put(7,  enc_i(OP_BEQ, 1, 0, 8'd1));
    put(8,  enc_i(OP_ADDI, 0, 4, 8'd1));
    put(9,  enc_r(2, 3, 1, F_SLT));
    put(10, enc_i(OP_BEQ, 1, 0, 8'd5));
    put(11, enc_j(13));
    put(12, enc_i(OP_ADDI, 0, 4, 8'd2));
    put(13, enc_i(OP_SB, 0, 4, 8'd100));
    put(14, enc_i(OP_LB, 0, 6, 8'd100));
    put(15, enc_i(OP_SB, 0, 6, 8'd76));
    put(16, enc_j(16));
    run_prog(140);
    chk("p3_nstores", 32'(st_addr.size()), 32'd2);
    if (st_addr.size() == 2) begin
      chk("p3_store0_addr", 32'(st_addr[0]), 32'd100);
      chk("p3_store0_data", 32'(st_data[0]), 32'd7);
      chk("p3_final_addr", 32'(st_addr[1]), 32'd76);
      chk("p3_final_data", 32'(st_data[1]), 32'd7);
    end

    // Program 4: writes to r0 are ignored
    clear_mem(1'b0);
    put(0, enc_i(OP_ADDI, 0, 0, 8'd9));
    put(1, enc_i(OP_SB, 0, 0, 8'd80));
    put(2, enc_j(2));
    run_prog(40);
    chk_one_store("p4", 8'd80, 8'd0);

    // Randomized programs: defined register prologue, then a random mix
    for (int s = 0; s < 4; s++) begin
      clear_mem(1'b1);
      for (int r = 1; r < 8; r++) put(r - 1, enc_i(OP_ADDI, 0, r, 8'($urandom)));
      for (int w = 7; w < 48; w++) begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0: put(w, enc_i(OP_LB, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          8'($urandom)));
          1: put(w, enc_i(OP_SB, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          8'($urandom)));
          2: put(w, enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), F_ADD));
          3: put(w, enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? F_SUB : F_SLT));
          4: put(w, enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? F_AND : F_OR));
          5: put(w, enc_i(OP_ADDI, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          8'($urandom)));
          6: put(w, enc_i(OP_BEQ, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          8'($urandom_range(0, 7))));
          7: put(w, enc_j(int'($urandom_range(0, 63))));
          8: put(w, {6'b111111, 26'($urandom)});
          default: put(w, enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), 6'($urandom)));
        endcase
      end
      run_prog(600);
    end

    // Reset pulsed during the store cycle
    clear_mem(1'b0);
    put(0, enc_i(OP_ADDI, 0, 1, 8'd5));
    put(1, enc_i(OP_SB, 0, 1, 8'd76));
    put(2, enc_j(2));
    mem[76] <= 8'hAA;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (memwrite !== 1'b1 && waited < 100);
    chk("abort_sbwr_seen", 32'(memwrite), 32'h1);
    chk("abort_sbwr_cycle", 32'(waited), 32'd14);
    #1 reset = 1'b0;
    #1;
    chk("abort_memwrite_drop", 32'(memwrite), 32'h0);
    chk("abort_addr_zero", 32'(addr), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("refetch_addr0", 32'(addr), 32'h0);
    @(negedge clk);
    chk("refetch_addr1", 32'(addr), 32'h1);
    chk("abort_no_store", 32'(mem[76]), 32'hAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
